// File: rtl/wordred_corr.sv
// ---------------------------------------------------------------------------
// wordred_corr
// Final correction stage of the word-level Montgomery reduction path.
// A partially reduced value T (possibly a few multiples of q above the
// canonical range) is brought into [0, q) by repeated subtraction of
// q = {qH, (W-1)'b0, 1'b1}. At most one subtraction is done per clock.
// If MAX_ITER subtractions still leave a value >= q, err is raised.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   qH         high part of the modulus, captured when an operand is accepted
//   in_valid   T_in is valid
//   in_ready   block can accept an operand (IDLE only)
//   T_in       value to correct
//   out_valid  R/err valid (DONE only), held until out_ready
//   out_ready  consumer takes R/err
//   R          corrected residue (low LOGQ bits of the accumulator)
//   err        accumulator still >= q after MAX_ITER subtractions
// ---------------------------------------------------------------------------
module wordred_corr #(
   parameter int W        = 34,
   parameter int LOGQH    = 26,
   parameter int I_SIZE   = 88,
   parameter int MAX_ITER = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [LOGQH-1:0]      qH,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [I_SIZE-1:0]     T_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [W+LOGQH-1:0]    R,
   output logic                  err
);

   localparam int LOGQ = W + LOGQH;
   localparam int AW   = I_SIZE + 1;
   localparam int CW   = $clog2(MAX_ITER + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_ITER);

   typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

   state_t            state;
   logic [AW-1:0]     acc;
   logic [LOGQH-1:0]  qh_q;
   logic [CW-1:0]     cnt;
   logic [AW-1:0]     q_full;
   logic              acc_ge_q;

   // Modulus widened to the accumulator width; low word is fixed to 1.
   assign q_full   = {{(AW-LOGQ){1'b0}}, qh_q, {(W-1){1'b0}}, 1'b1};
   assign acc_ge_q = (acc >= q_full);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         qh_q      <= '0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         R         <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc      <= {1'b0, T_in};
                  qh_q     <= qH;
                  cnt      <= '0;
                  err      <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= SUB;
               end
            end

            SUB: begin
               if (acc_ge_q && (cnt < CNT_MAX)) begin
                  acc <= acc - q_full;
                  cnt <= cnt + 1'b1;
               end else begin
                  // Either canonical already, or out of subtraction budget;
                  // acc is left untouched in the budget-exhausted case.
                  R         <= acc[LOGQ-1:0];
                  err       <= acc_ge_q;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
